audio_wdg_gate: RTL and testbench

Multi-channel watchdog gate for the speaker/tone datapath. Each of `CH` channels carries a `W`-bit sample and has its own countdown timer. A per-channel `kick` (keypress strobe) reloads the timer. A channel that is not kicked within `TIMEOUT` cycles is muted, optionally after a stepped amplitude decay. The block sits between the tone generators and the speaker output mux, so that a stuck or released key silences its channel.

---
 rtl/audio_wdg_gate.sv | 146 ++++++++++++++
 tb/tb_audio_wdg_gate.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/audio_wdg_gate.sv
// rtl/audio_wdg_gate.sv - per-channel kick watchdog that gates speaker samples; define AUDIO_WDG_DECAY_EN for stepped decay before mute
module audio_wdg_gate #(
    parameter int CH         = 4,
    parameter int W          = 8,
    parameter int TIMEOUT    = 25000000,
    parameter int CNT_W      = 32,
    parameter int DECAY_STEP = 1000000
) (
    input  logic            clk,
    input  logic            RST,
    input  logic [CH-1:0]   kick,
    input  logic [CH*W-1:0] data_in,
    output logic [CH*W-1:0] data_out,
    output logic [CH-1:0]   active,
    output logic [CH-1:0]   expired,
    output logic            any_active
);

    typedef enum logic [1:0] {
        S_ACTIVE = 2'd0,
        S_DECAY  = 2'd1,
        S_MUTED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
`ifdef AUDIO_WDG_DECAY_EN
    localparam int               SH_W      = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(DECAY_STEP - 1);
    localparam logic [SH_W-1:0]  SH_LAST   = SH_W'(W - 1);
`endif

    if (CH < 1 || W < 2 || TIMEOUT < 1 || DECAY_STEP < 1) begin : g_param_check
        $error("audio_wdg_gate: illegal parameter value");
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t           state, state_nx;
        logic [CNT_W-1:0] cnt, cnt_nx;
        logic             exp_nx;
        logic [W-1:0]     sample, gated, dout_q;
        logic             act_q, exp_q;
`ifdef AUDIO_WDG_DECAY_EN
        logic [SH_W-1:0]  shift, shift_nx;
        logic [CNT_W-1:0] dcnt, dcnt_nx;
`endif

        assign sample = data_in[i*W +: W];

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            exp_nx   = 1'b0;
`ifdef AUDIO_WDG_DECAY_EN
            shift_nx = shift;
            dcnt_nx  = dcnt;
`endif
            case (state)
                S_ACTIVE: begin
                    if (kick[i]) begin
                        cnt_nx = TIMEOUT_C;
                    end else if (cnt == '0) begin
                        exp_nx = 1'b1;
`ifdef AUDIO_WDG_DECAY_EN
                        state_nx = S_DECAY;
                        shift_nx = SH_W'(1);
                        dcnt_nx  = STEP_C;
`else
                        state_nx = S_MUTED;
`endif
                    end else begin
                        cnt_nx = cnt - CNT_W'(1);
                    end
                end
`ifdef AUDIO_WDG_DECAY_EN
                S_DECAY: begin
                    if (kick[i]) begin
                        state_nx = S_ACTIVE;
                        cnt_nx   = TIMEOUT_C;
                        shift_nx = '0;
                        dcnt_nx  = '0;
                    end else if (dcnt == '0) begin
                        dcnt_nx = STEP_C;
                        // The last shift step is W-1; one more step means silence.
                        if (shift == SH_LAST) begin
                            state_nx = S_MUTED;
                            shift_nx = '0;
                        end else begin
                            shift_nx = shift + SH_W'(1);
                        end
                    end else begin
                        dcnt_nx = dcnt - CNT_W'(1);
                    end
                end
`endif
                default: begin
                    if (kick[i]) begin
                        state_nx = S_ACTIVE;
                        cnt_nx   = TIMEOUT_C;
                    end
                end
            endcase
        end

        always_comb begin
            gated = '0;
            case (state)
                S_ACTIVE: gated = sample;
`ifdef AUDIO_WDG_DECAY_EN
                S_DECAY:  gated = sample >> shift;
`endif
                default:  gated = '0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (RST) begin
                state  <= S_ACTIVE;
                cnt    <= TIMEOUT_C;
                dout_q <= '0;
                act_q  <= 1'b1;
                exp_q  <= 1'b0;
`ifdef AUDIO_WDG_DECAY_EN
                shift  <= '0;
                dcnt   <= '0;
`endif
            end else begin
                state  <= state_nx;
                cnt    <= cnt_nx;
                dout_q <= gated;
                act_q  <= (state_nx == S_ACTIVE);
                exp_q  <= exp_nx;
`ifdef AUDIO_WDG_DECAY_EN
                shift  <= shift_nx;
                dcnt   <= dcnt_nx;
`endif
            end
        end

        assign data_out[i*W +: W] = dout_q;
        assign active[i]          = act_q;
        assign expired[i]         = exp_q;
    end

    assign any_active = |active;

endmodule

// File: tb/tb_audio_wdg_gate.sv
// tb/tb_audio_wdg_gate.sv - self-checking bench for audio_wdg_gate with an age-based reference model
module tb_audio_wdg_gate;
    localparam int CH         = 2;
    localparam int W          = 8;
    localparam int TIMEOUT    = 10;
    localparam int CNT_W      = 16;
    localparam int DECAY_STEP = 4;

    logic            clk = 1'b0;
    logic            RST;
    logic [CH-1:0]   kick;
    logic [CH*W-1:0] data_in;
    logic [CH*W-1:0] data_out;
    logic [CH-1:0]   active;
    logic [CH-1:0]   expired;
    logic            any_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_wdg_gate #(
        .CH(CH), .W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .DECAY_STEP(DECAY_STEP)
    ) dut (
        .clk(clk), .RST(RST), .kick(kick), .data_in(data_in),
        .data_out(data_out), .active(active), .expired(expired), .any_active(any_active)
    );

    // Model: a channel is described only by edges elapsed since its last kick/reset.
    int           age [CH];
    logic [W-1:0] m_dout [CH];
    logic [CH-1:0] m_act;
    logic [CH-1:0] m_exp;
    bit           m_valid = 1'b0;

    function automatic logic [W-1:0] gate_model(input int a, input logic [W-1:0] s);
        if (a <= TIMEOUT) return s;
`ifdef AUDIO_WDG_DECAY_EN
        begin
            int sh;
            sh = 1 + (a - (TIMEOUT + 1)) / DECAY_STEP;
            if (sh < W) return s >> sh;
        end
`endif
        return '0;
    endfunction

    always @(posedge clk) begin
        if (RST) begin
            for (int c = 0; c < CH; c++) begin
                age[c]    = 0;
                m_dout[c] = '0;
            end
            m_act   = '1;
            m_exp   = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int c = 0; c < CH; c++) begin
                m_dout[c] = gate_model(age[c], data_in[c*W +: W]);
                if (kick[c]) age[c] = 0;
                else if (age[c] < 1000000) age[c] = age[c] + 1;
                m_exp[c] = (age[c] == TIMEOUT + 1);
                m_act[c] = (age[c] <= TIMEOUT);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            for (int c = 0; c < CH; c++)
                chk($sformatf("model_dout%0d", c), 32'(data_out[c*W +: W]), 32'(m_dout[c]));
            chk("model_active", 32'(active), 32'(m_act));
            chk("model_expired", 32'(expired), 32'(m_exp));
            chk("model_any_active", 32'(any_active), 32'(|m_act));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        kick = '0;
        data_in = 16'h55AA;
        @(negedge clk);
        chk("rst_dout", 32'(data_out), 32'h0000);
        chk("rst_active", 32'(active), 32'h3);
        chk("rst_any_active", 32'(any_active), 32'h1);
        RST = 1'b0;
        @(negedge clk);
        chk("rst_pass", 32'(data_out), 32'h55AA);

        // Timeout with ch1 held kicked; ch0 expires after edge 11.
        data_in = 16'h33F0;
        kick = 2'b10;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 11) begin
                chk("to_dout11", 32'(data_out[7:0]), 32'hF0);
                chk("to_exp11", 32'(expired), 32'h1);
                chk("to_act11", 32'(active), 32'h2);
            end
            if (n == 12) begin
                chk("to_exp12", 32'(expired), 32'h0);
`ifdef AUDIO_WDG_DECAY_EN
                chk("to_dout12", 32'(data_out[7:0]), 32'h78);
`else
                chk("to_dout12", 32'(data_out[7:0]), 32'h00);
`endif
            end
`ifdef AUDIO_WDG_DECAY_EN
            if (n == 15) chk("dec_dout15", 32'(data_out[7:0]), 32'h78);
            if (n == 16) chk("dec_dout16", 32'(data_out[7:0]), 32'h3C);
            if (n == 24) chk("dec_dout24", 32'(data_out[7:0]), 32'h0F);
            if (n == 39) chk("dec_dout39", 32'(data_out[7:0]), 32'h01);
            if (n == 40) chk("dec_dout40", 32'(data_out[7:0]), 32'h00);
`endif
            if (n == 20) chk("to_ch1_pass", 32'(data_out[15:8]), 32'h33);
        end

        // Kick on the cycle count reaches zero.
        kick = 2'b10;
        do_reset();
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 11) chk("bd_exp11", 32'(expired[0]), 32'h0);
            if (n == 21) chk("bd_exp21", 32'(expired[0]), 32'h0);
            if (n == 22) begin
                chk("bd_exp22", 32'(expired[0]), 32'h1);
                chk("bd_dout22", 32'(data_out[7:0]), 32'hF0);
            end
            if (n == 23) chk("bd_act23", 32'(active[0]), 32'h0);
            kick[0] = (n == 10);
        end

        // Kick after expiry (during DECAY, or MUTED without decay).
        kick = 2'b10;
        do_reset();
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
`ifdef AUDIO_WDG_DECAY_EN
            if (n == 20) chk("kd_dout20", 32'(data_out[7:0]), 32'h1E);
`endif
            if (n == 22) chk("kd_act22", 32'(active[0]), 32'h1);
            if (n == 23) chk("kd_dout23", 32'(data_out[7:0]), 32'hF0);
            if (n == 32) chk("kd_exp32", 32'(expired[0]), 32'h0);
            if (n == 33) chk("kd_exp33", 32'(expired[0]), 32'h1);
            kick[0] = (n == 21);
        end

        // Independence: ch0 left to mute, ch1 kicked every 5 cycles, then ch0 recovers.
        data_in = 16'hA5F0;
        kick = '0;
        do_reset();
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == 30) begin
                chk("ind_ch1_pass", 32'(data_out[15:8]), 32'hA5);
                chk("ind_any_active", 32'(any_active), 32'h1);
            end
            if (n == 44) chk("ind_ch0_muted", 32'(data_out[7:0]), 32'h00);
            if (n == 47) chk("ind_ch0_back", 32'(data_out[7:0]), 32'hF0);
            kick[1] = (n % 5 == 0);
            kick[0] = (n == 45);
        end

        // Randomized traffic with sparse kicks and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            data_in = 16'($urandom);
            for (int c = 0; c < CH; c++)
                kick[c] = (n % 1000 < 500) ? ($urandom_range(0, 11) == 0)
                                           : ($urandom_range(0, 59) == 0);
            RST = ($urandom_range(0, 299) == 0);
        end
        RST = 1'b0;
        kick = '0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
